sys_umul_arb: RTL

- Shares one sequential shift-add unsigned multiplier between NUM_REQ requesters, e.g. video scaler, audio volume and CPU-side helpers that each need an occasional wide product.
- Each requester presents operands with a level request. The arbiter grants, runs the multiply, and returns the result with a per-requester done pulse.
- Sits between the core-side requesters and an internal multiplier sub-module. One product is in flight at a time.

---
 rtl/sys_umul_arb_pkg.sv | 23 ++
 rtl/sys_umul_core.sv | 57 +++++
 rtl/sys_umul_arb.sv | 113 +++++++++++
 3 files changed

// File: rtl/sys_umul_arb_pkg.sv
// sys_umul_arb_pkg: shared FSM state type, requester limit and winner-selection helpers
package sys_umul_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int last, input int n);
    int idx;
    rr_pick = last;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = (last + 1 + k) % n;
      if (k < n && req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic int fp_pick(input logic [MAX_REQ-1:0] req);
    fp_pick = 0;
    for (int k = MAX_REQ - 1; k >= 0; k--)
      if (req[k]) fp_pick = k;
  endfunction

endpackage

// File: rtl/sys_umul_core.sv
// sys_umul_core: sequential shift-add unsigned multiplier that stops once the remaining mul2 bits are zero
module sys_umul_core
  import sys_umul_arb_pkg::*;
#(
  parameter int NB_MUL1 = 16,
  parameter int NB_MUL2 = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [NB_MUL1-1:0]         mul1,
  input  logic [NB_MUL2-1:0]         mul2,
  output logic                       busy,
  output logic                       done,
  output logic [NB_MUL1+NB_MUL2-1:0] result
);

  localparam int NB_RES = NB_MUL1 + NB_MUL2;

  logic [NB_RES-1:0]  r_acc;
  logic [NB_RES-1:0]  r_add;
  logic [NB_MUL2-1:0] r_map;
  logic               r_busy;
  logic               r_done;

  // load on start, then add the shifted multiplicand for each set map bit until the map empties
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_acc  <= '0;
      r_add  <= '0;
      r_map  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_acc  <= '0;
        r_add  <= NB_RES'(mul1);
        r_map  <= mul2;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_map == '0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          if (r_map[0]) r_acc <= r_acc + r_add;
          r_add <= r_add << 1;
          r_map <= r_map >> 1;
        end
      end
    end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_acc;

endmodule

// File: rtl/sys_umul_arb.sv
// sys_umul_arb: arbitrates NUM_REQ requesters onto one shared multiplier; SYS_UMUL_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin
module sys_umul_arb
  import sys_umul_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NB_MUL1 = 16,
  parameter int NB_MUL2 = 16,
  localparam int NB_OWN = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*NB_MUL1-1:0] mul1,
  input  logic [NUM_REQ*NB_MUL2-1:0] mul2,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [NB_MUL1+NB_MUL2-1:0] result,
  output logic                       busy,
  output logic [NB_OWN-1:0]          owner
);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic   [NB_OWN-1:0]        r_owner;
  logic   [NB_OWN-1:0]        w_win;
  logic   [NB_MUL1-1:0]       r_op1;
  logic   [NB_MUL2-1:0]       r_op2;
  logic   [NB_MUL1+NB_MUL2-1:0] r_result;
  logic   [NUM_REQ-1:0]       w_onehot;
  logic                       w_core_start;
  logic                       w_core_busy;
  logic                       w_core_done;
  logic   [NB_MUL1+NB_MUL2-1:0] w_core_result;

`ifdef SYS_UMUL_ARB_FIXED_PRIO_EN
  // lowest requesting index wins
  always_comb w_win = NB_OWN'(fp_pick(MAX_REQ'(req)));
`else
  logic [NB_OWN-1:0] r_ptr;

  // search starts one past the last winner and wraps at NUM_REQ
  always_comb w_win = NB_OWN'(rr_pick(MAX_REQ'(req), int'(r_ptr), NUM_REQ));

  // pointer remembers the last winner and moves only on a grant
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_ptr <= '0;
    else if (r_state == IDLE && |req) r_ptr <= w_win;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_state_nxt;

  assign w_onehot = NUM_REQ'(1) << r_owner;

  // next state plus the single-cycle grant, core start and done pulses
  always_comb begin
    w_state_nxt  = r_state;
    w_core_start = 1'b0;
    gnt          = '0;
    done         = '0;
    unique case (r_state)
      IDLE:  w_state_nxt = |req ? START : IDLE;
      START: begin
        w_state_nxt  = RUN;
        w_core_start = 1'b1;
        gnt          = w_onehot;
      end
      RUN:   w_state_nxt = w_core_done ? DONE : RUN;
      DONE:  begin
        w_state_nxt = IDLE;
        done        = w_onehot;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // capture winner and its operands at grant, and the product when the core finishes
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_owner  <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_result <= '0;
    end else begin
      if (r_state == IDLE && |req) begin
        r_owner <= w_win;
        r_op1   <= mul1[w_win*NB_MUL1 +: NB_MUL1];
        r_op2   <= mul2[w_win*NB_MUL2 +: NB_MUL2];
      end
      if (r_state == RUN && w_core_done) r_result <= w_core_result;
    end

  sys_umul_core #(
    .NB_MUL1 (NB_MUL1),
    .NB_MUL2 (NB_MUL2)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (w_core_start),
    .mul1    (r_op1),
    .mul2    (r_op2),
    .busy    (w_core_busy),
    .done    (w_core_done),
    .result  (w_core_result)
  );

  assign busy   = (r_state == START) || (r_state == RUN) || w_core_busy;
  assign result = r_result;
  assign owner  = r_owner;

endmodule
